// File: rtl/int_iq4_issue_ctrl.sv
// 8-entry integer issue-queue controller: allocates slots from the IQ free list,
// tracks operand readiness, issues the oldest ready micro-op and returns its slot tag.
module int_iq4_issue_ctrl #(
    parameter int UOPW  = 32,
    parameter int PREGW = 6,
    parameter int SLOTW = 5
) (
    input  logic             Clk,
    input  logic             Rest,
    input  logic             DispValid,
    input  logic [UOPW-1:0]  DispUop,
    input  logic [PREGW-1:0] DispSrc1,
    input  logic [PREGW-1:0] DispSrc2,
    input  logic             DispRdy1,
    input  logic             DispRdy2,
    output logic             DispReady,
    input  logic             FreeEmpty,
    input  logic [SLOTW-1:0] FreePreOut,
    output logic             FreeRable,
    output logic             FreeWable,
    output logic [SLOTW-1:0] FreeDin,
    output logic             FreeClean,
    input  logic             WakeValid,
    input  logic [PREGW-1:0] WakeTag,
    output logic             IssueValid,
    output logic [UOPW-1:0]  IssueUop,
    output logic [SLOTW-1:0] IssueSlot,
    input  logic             IssueReady,
    input  logic             Flush
);

    localparam int N = 8;

    logic [N-1:0]     valid;
    logic [N-1:0]     rdy1;
    logic [N-1:0]     rdy2;
    logic [UOPW-1:0]  uop  [N];
    logic [PREGW-1:0] src1 [N];
    logic [PREGW-1:0] src2 [N];
    logic [N-1:0]     age  [N];

    logic [N-1:0] ready;
    logic [N-1:0] win_oh;
    logic [2:0]   win_idx;
    logic         found;
    logic         disp_ok;
    logic         fire;
    logic [2:0]   disp_idx;
    logic [N-1:0] disp_oh;
    logic [N-1:0] issue_oh;
    logic         wake1;
    logic         wake2;

    assign ready = valid & rdy1 & rdy2;

    // Age matrix guarantees a single oldest ready entry; the scan just encodes it.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && ready[i] && ((age[i] & ready) == '0)) begin
                found      = 1'b1;
                win_idx    = 3'(i);
                win_oh[i]  = 1'b1;
            end
        end
    end

    assign disp_ok  = Rest & DispValid & ~FreeEmpty & ~Flush;
    assign disp_idx = FreePreOut[4:2];
    assign disp_oh  = disp_ok ? (N'(1) << disp_idx) : '0;

    assign IssueValid = Rest & ~Flush & (|ready);
    assign fire       = IssueValid & IssueReady;
    assign issue_oh   = fire ? win_oh : '0;

    assign DispReady = disp_ok;
    assign FreeRable = disp_ok;
    assign FreeWable = fire;
    assign FreeClean = Rest & Flush;
    assign IssueSlot = IssueValid ? {win_idx, 2'b11} : '0;
    assign IssueUop  = IssueValid ? uop[win_idx] : '0;
    assign FreeDin   = fire ? IssueSlot : '0;

    assign wake1 = WakeValid && (WakeTag == DispSrc1);
    assign wake2 = WakeValid && (WakeTag == DispSrc2);

    always_ff @(posedge Clk) begin
        if (!Rest || Flush) begin
            valid <= '0;
            rdy1  <= '0;
            rdy2  <= '0;
            for (int i = 0; i < N; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (disp_oh[i]) begin
                    valid[i] <= 1'b1;
                    uop[i]   <= DispUop;
                    src1[i]  <= DispSrc1;
                    src2[i]  <= DispSrc2;
                    rdy1[i]  <= DispRdy1 | wake1;
                    rdy2[i]  <= DispRdy2 | wake2;
                    age[i]   <= valid & ~issue_oh;
                end else begin
                    if (issue_oh[i])
                        valid[i] <= 1'b0;
                    if (valid[i] && WakeValid && WakeTag == src1[i])
                        rdy1[i] <= 1'b1;
                    if (valid[i] && WakeValid && WakeTag == src2[i])
                        rdy2[i] <= 1'b1;
                    age[i] <= age[i] & ~(disp_oh | issue_oh);
                end
            end
        end
    end

endmodule

// File: tb/tb_int_iq4_issue_ctrl.sv
// Directed bench for int_iq4_issue_ctrl: dispatch order, wakeup, back-pressure,
// stall hold, same-cycle wakeup and flush.
module tb_int_iq4_issue_ctrl;

    logic        Clk = 1'b0;
    logic        Rest;
    logic        DispValid;
    logic [31:0] DispUop;
    logic [5:0]  DispSrc1;
    logic [5:0]  DispSrc2;
    logic        DispRdy1;
    logic        DispRdy2;
    logic        DispReady;
    logic        FreeEmpty;
    logic [4:0]  FreePreOut;
    logic        FreeRable;
    logic        FreeWable;
    logic [4:0]  FreeDin;
    logic        FreeClean;
    logic        WakeValid;
    logic [5:0]  WakeTag;
    logic        IssueValid;
    logic [31:0] IssueUop;
    logic [4:0]  IssueSlot;
    logic        IssueReady;
    logic        Flush;

    int checks = 0;
    int failures = 0;

    int_iq4_issue_ctrl dut (
        .Clk(Clk), .Rest(Rest),
        .DispValid(DispValid), .DispUop(DispUop),
        .DispSrc1(DispSrc1), .DispSrc2(DispSrc2),
        .DispRdy1(DispRdy1), .DispRdy2(DispRdy2),
        .DispReady(DispReady),
        .FreeEmpty(FreeEmpty), .FreePreOut(FreePreOut),
        .FreeRable(FreeRable), .FreeWable(FreeWable),
        .FreeDin(FreeDin), .FreeClean(FreeClean),
        .WakeValid(WakeValid), .WakeTag(WakeTag),
        .IssueValid(IssueValid), .IssueUop(IssueUop),
        .IssueSlot(IssueSlot), .IssueReady(IssueReady),
        .Flush(Flush)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic disp(input logic [31:0] u, input logic [5:0] s1,
                        input logic r1, input logic [4:0] tag);
        DispValid  = 1'b1;
        DispUop    = u;
        DispSrc1   = s1;
        DispSrc2   = 6'd0;
        DispRdy1   = r1;
        DispRdy2   = 1'b1;
        FreePreOut = tag;
    endtask

    initial begin
        Rest = 1'b0; Flush = 1'b0; FreeEmpty = 1'b0;
        WakeValid = 1'b0; WakeTag = '0; IssueReady = 1'b1;
        disp(32'h55, 6'd0, 1'b1, 5'd3);
        #2;
        check("rst_disp_ready", DispReady, 0);
        check("rst_free_rable", FreeRable, 0);
        check("rst_issue_valid", IssueValid, 0);
        check("rst_free_wable", FreeWable, 0);
        check("rst_free_clean", FreeClean, 0);
        check("rst_issue_slot", IssueSlot, 0);
        step();
        step();

        // in-order issue of three ready uops
        Rest = 1'b1;
        disp(32'h100, 6'd0, 1'b1, 5'd3);
        #1;
        check("t1_disp_ready", DispReady, 1);
        check("t1_free_rable", FreeRable, 1);
        check("t1_no_bypass", IssueValid, 0);
        step();
        disp(32'h101, 6'd0, 1'b1, 5'd7);
        #1;
        check("t1_iv0", IssueValid, 1);
        check("t1_slot0", IssueSlot, 3);
        check("t1_uop0", IssueUop, 32'h100);
        check("t1_fw0", FreeWable, 1);
        check("t1_din0", FreeDin, 3);
        step();
        disp(32'h102, 6'd0, 1'b1, 5'd11);
        #1;
        check("t1_slot1", IssueSlot, 7);
        check("t1_din1", FreeDin, 7);
        step();
        DispValid = 1'b0;
        #1;
        check("t1_slot2", IssueSlot, 11);
        check("t1_uop2", IssueUop, 32'h102);
        check("t1_din2", FreeDin, 11);
        step();
        #1;
        check("t1_drained", IssueValid, 0);
        check("t1_fw_idle", FreeWable, 0);

        // younger ready uop bypasses older waiting one
        step();
        disp(32'hA, 6'd5, 1'b0, 5'd15);
        #1;
        check("t2_a_wait", IssueValid, 0);
        step();
        disp(32'hB, 6'd0, 1'b1, 5'd19);
        #1;
        check("t2_a_still", IssueValid, 0);
        step();
        DispValid = 1'b0;
        WakeValid = 1'b1;
        WakeTag   = 6'd5;
        #1;
        check("t2_b_slot", IssueSlot, 19);
        check("t2_b_uop", IssueUop, 32'hB);
        step();
        WakeValid = 1'b0;
        #1;
        check("t2_a_slot", IssueSlot, 15);
        check("t2_a_uop", IssueUop, 32'hA);
        check("t2_a_din", FreeDin, 15);
        step();
        #1;
        check("t2_drained", IssueValid, 0);

        // fill all 8 slots with waiting uops, then back-pressure
        for (int k = 0; k < 8; k++) begin
            step();
            disp(32'h200 + k, 6'd33, 1'b0, 5'(4 * k + 3));
            #1;
            check("t3_fill_ready", DispReady, 1);
            check("t3_fill_iv", IssueValid, 0);
        end
        step();
        FreeEmpty = 1'b1;
        disp(32'h2FF, 6'd33, 1'b0, 5'd3);
        #1;
        check("t3_full_ready", DispReady, 0);
        check("t3_full_rable", FreeRable, 0);
        check("t3_full_iv", IssueValid, 0);

        // wake all, stall for 3 cycles on the oldest
        step();
        DispValid  = 1'b0;
        WakeValid  = 1'b1;
        WakeTag    = 6'd33;
        IssueReady = 1'b0;
        #1;
        check("t4_not_yet", IssueValid, 0);
        for (int c = 0; c < 3; c++) begin
            step();
            WakeValid = 1'b0;
            #1;
            check("t4_stall_iv", IssueValid, 1);
            check("t4_stall_slot", IssueSlot, 3);
            check("t4_stall_fw", FreeWable, 0);
        end
        step();
        IssueReady = 1'b1;
        #1;
        check("t4_go_fw", FreeWable, 1);
        check("t4_go_din", FreeDin, 3);
        check("t4_go_uop", IssueUop, 32'h200);
        step();
        #1;
        check("t4_next_slot", IssueSlot, 7);
        step();
        #1;
        check("t4_third_din", FreeDin, 11);

        // flush with 5 entries left and a stalled issue
        step();
        IssueReady = 1'b0;
        #1;
        check("t6_pre_iv", IssueValid, 1);
        check("t6_pre_slot", IssueSlot, 15);
        step();
        Flush     = 1'b1;
        FreeEmpty = 1'b0;
        disp(32'h3FF, 6'd0, 1'b1, 5'd23);
        #1;
        check("t6_clean", FreeClean, 1);
        check("t6_iv", IssueValid, 0);
        check("t6_fw", FreeWable, 0);
        check("t6_disp_ready", DispReady, 0);
        check("t6_rable", FreeRable, 0);
        step();
        Flush      = 1'b0;
        DispValid  = 1'b0;
        IssueReady = 1'b1;
        #1;
        check("t6_post_iv", IssueValid, 0);
        check("t6_post_clean", FreeClean, 0);

        // dispatch with a same-cycle wakeup of its source
        step();
        disp(32'h300, 6'd9, 1'b0, 5'd3);
        WakeValid = 1'b1;
        WakeTag   = 6'd9;
        #1;
        check("t5_disp_ready", DispReady, 1);
        check("t5_no_bypass", IssueValid, 0);
        step();
        DispValid = 1'b0;
        WakeValid = 1'b0;
        #1;
        check("t5_iv", IssueValid, 1);
        check("t5_slot", IssueSlot, 3);
        check("t5_uop", IssueUop, 32'h300);
        check("t5_din", FreeDin, 3);
        step();
        #1;
        check("t5_drained", IssueValid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
